// File: rtl/viterbi_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_encoder_if
// Brief    : Word-in / serial-coded-bit-out bus of the K=7 convolutional encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface viterbi_encoder_if;
    logic [17:0] data_in;
    logic        valid_in;
    logic        ready;
    logic        out;
    logic        valid_out;
    logic        frame_start;

    modport master (
        output data_in, valid_in,
        input  ready, out, valid_out, frame_start
    );

    modport slave (
        input  data_in, valid_in,
        output ready, out, valid_out, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/viterbi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_encoder
// Brief    : Rate-1/2 K=7 (133/171) encoder, 18-bit frames, serial A/B output.
//            Define VITERBI_ENC_TAIL_EN to append 6 zero tail bits per frame.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_encoder (
    input  logic             Clk,
    input  logic             reset,
    viterbi_encoder_if.slave bus
);

`ifdef VITERBI_ENC_TAIL_EN
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, TAIL_A, TAIL_B} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B} state_t;
`endif

    localparam logic [4:0] LAST_BIT  = 5'd17;
    localparam logic [4:0] LAST_TAIL = 5'd5;

    state_t      state_q;
    logic [5:0]  sr_q;
    logic [17:0] word_q;
    logic [4:0]  cnt_q;
    logic        out_q;
    logic        valid_out_q;
    logic        frame_start_q;
    logic        ready_q;

    logic        commit_bit_w;
    logic [5:0]  sr_d;
    logic [5:0]  sr_base_w;
    logic        accept_w;

    function automatic logic code_a(input logic u, input logic [5:0] s);
        return u ^ s[4] ^ s[3] ^ s[1] ^ s[0];
    endfunction

    function automatic logic code_b(input logic u, input logic [5:0] s);
        return u ^ s[5] ^ s[4] ^ s[3] ^ s[0];
    endfunction

    // sr_d is the trellis state once the bit shown on this B cycle is committed
    assign commit_bit_w = (state_q == SEND_B) ? word_q[17] : 1'b0;
    assign sr_d         = {commit_bit_w, sr_q[5:1]};
    assign sr_base_w    = (state_q == IDLE) ? sr_q : sr_d;
    assign accept_w     = bus.valid_in && ready_q;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sr_q          <= 6'd0;
            word_q        <= 18'd0;
            cnt_q         <= 5'd0;
            out_q         <= 1'b0;
            valid_out_q   <= 1'b0;
            frame_start_q <= 1'b0;
            ready_q       <= 1'b0;
        end else if (accept_w) begin
            // ready is only high in IDLE or on the last B, so this starts a frame
            state_q       <= SEND_A;
            sr_q          <= sr_base_w;
            word_q        <= bus.data_in;
            cnt_q         <= 5'd0;
            out_q         <= code_a(bus.data_in[17], sr_base_w);
            valid_out_q   <= 1'b1;
            frame_start_q <= 1'b1;
            ready_q       <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q     <= 1'b1;
                    valid_out_q <= 1'b0;
                    out_q       <= 1'b0;
                end
                SEND_A: begin
                    state_q     <= SEND_B;
                    out_q       <= code_b(word_q[17], sr_q);
                    valid_out_q <= 1'b1;
`ifdef VITERBI_ENC_TAIL_EN
                    ready_q     <= 1'b0;
`else
                    ready_q     <= (cnt_q == LAST_BIT);
`endif
                end
                SEND_B: begin
                    sr_q   <= sr_d;
                    word_q <= {word_q[16:0], 1'b0};
                    if (cnt_q == LAST_BIT) begin
`ifdef VITERBI_ENC_TAIL_EN
                        state_q     <= TAIL_A;
                        cnt_q       <= 5'd0;
                        out_q       <= code_a(1'b0, sr_d);
                        valid_out_q <= 1'b1;
`else
                        state_q     <= IDLE;
                        out_q       <= 1'b0;
                        valid_out_q <= 1'b0;
`endif
                    end else begin
                        state_q     <= SEND_A;
                        cnt_q       <= cnt_q + 5'd1;
                        out_q       <= code_a(word_q[16], sr_d);
                        valid_out_q <= 1'b1;
                    end
                end
`ifdef VITERBI_ENC_TAIL_EN
                TAIL_A: begin
                    state_q     <= TAIL_B;
                    out_q       <= code_b(1'b0, sr_q);
                    valid_out_q <= 1'b1;
                    ready_q     <= (cnt_q == LAST_TAIL);
                end
                TAIL_B: begin
                    sr_q <= sr_d;
                    if (cnt_q == LAST_TAIL) begin
                        state_q     <= IDLE;
                        out_q       <= 1'b0;
                        valid_out_q <= 1'b0;
                    end else begin
                        state_q     <= TAIL_A;
                        cnt_q       <= cnt_q + 5'd1;
                        out_q       <= code_a(1'b0, sr_d);
                        valid_out_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    out_q       <= 1'b0;
                    valid_out_q <= 1'b0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.out         = out_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire
